// File: rtl/spi_cmd_parser_if.sv
// Register-bus side of the SPI command parser: received words in, write/read strobes and
// transmit data out.
interface spi_cmd_parser_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  i_rx_evt;
  logic [WORD_WIDTH-1:0] i_rx_data;
  logic                  o_wr_en;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic [WORD_WIDTH-1:0] o_wr_data;
  logic                  o_rd_en;
  logic [ADDR_WIDTH-1:0] o_rd_addr;
  logic                  i_rd_ack;
  logic [WORD_WIDTH-1:0] i_rd_data;
  logic                  o_tx_valid;
  logic [WORD_WIDTH-1:0] o_tx_data;
  logic                  o_err;
  logic                  o_err_sticky;
  logic                  i_err_clr;

  modport slave (
    input  i_rx_evt, i_rx_data, i_rd_ack, i_rd_data, i_err_clr,
    output o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr,
    output o_tx_valid, o_tx_data, o_err, o_err_sticky
  );

  modport master (
    output i_rx_evt, i_rx_data, i_rd_ack, i_rd_data, i_err_clr,
    input  o_wr_en, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr,
    input  o_tx_valid, o_tx_data, o_err, o_err_sticky
  );
endinterface

// File: rtl/spi_cmd_parser.sv
// Decodes SPI received words (header + burst data/dummies) into register-bus writes and reads;
// frames end after an inter-word silence.
module spi_cmd_parser #(
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned WORD_TIMEOUT = 32'd4000,
  parameter int unsigned ACK_TIMEOUT  = 32'd256
) (
  input logic               user_clk,
  input logic               user_rst_n,
  spi_cmd_parser_if.slave   bus_io
);

  typedef enum logic [2:0] {StIdle, StWrData, StRdReq, StRdWait, StRdNext} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           word_tmr_q, word_tmr_d;
  logic [31:0]           ack_tmr_q, ack_tmr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [WORD_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  err_q, err_d;
  logic                  err_sticky_q, err_sticky_d;

  logic rx_evt, ack_hit, ack_expired, word_expired;

  always_comb begin
    rx_evt       = bus_io.i_rx_evt;
    ack_hit      = (state_q == StRdWait) && bus_io.i_rd_ack;
    ack_expired  = (state_q == StRdWait) && !bus_io.i_rd_ack &&
                   (ack_tmr_q == 32'(ACK_TIMEOUT - 1));
    // A word arriving in the expiry cycle keeps the frame alive.
    word_expired = (state_q != StIdle) && !rx_evt && (word_tmr_q == 32'(WORD_TIMEOUT - 1));
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) state_q <= StIdle;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rx_evt) state_d = bus_io.i_rx_data[WORD_WIDTH-1] ? StRdReq : StWrData;
      StWrData: if (word_expired) state_d = StIdle;
      StRdReq:  state_d = StRdWait;
      StRdWait: begin
        if (ack_hit || ack_expired) state_d = StRdNext;
        else if (word_expired)      state_d = StIdle;
      end
      StRdNext: begin
        if (rx_evt)            state_d = StRdReq;
        else if (word_expired) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    tx_valid_d   = 1'b0;
    tx_data_d    = tx_data_q;
    err_d        = 1'b0;
    word_tmr_d   = (state_q == StIdle || rx_evt || word_expired) ? 32'd0 : word_tmr_q + 32'd1;
    ack_tmr_d    = (state_q == StRdWait && !ack_hit && !ack_expired) ? ack_tmr_q + 32'd1 : 32'd0;
    unique case (state_q)
      StIdle: begin
        if (rx_evt) begin
          addr_d = bus_io.i_rx_data[ADDR_WIDTH-1:0];
          if (bus_io.i_rx_data[WORD_WIDTH-1]) begin
            rd_en_d   = 1'b1;
            rd_addr_d = bus_io.i_rx_data[ADDR_WIDTH-1:0];
          end
        end
      end
      StWrData: begin
        if (rx_evt) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = bus_io.i_rx_data;
          addr_d    = addr_q + AddrOne;
        end
      end
      StRdWait: begin
        if (ack_hit) begin
          tx_valid_d = 1'b1;
          tx_data_d  = bus_io.i_rd_data;
          addr_d     = addr_q + AddrOne;
        end else if (ack_expired) begin
          tx_valid_d = 1'b1;
          tx_data_d  = '0;
          err_d      = 1'b1;
          addr_d     = addr_q + AddrOne;
        end
      end
      StRdNext: begin
        if (rx_evt) begin
          rd_en_d   = 1'b1;
          rd_addr_d = addr_q;
        end
      end
      default: ;
    endcase
    err_sticky_d = err_d | (err_sticky_q & ~bus_io.i_err_clr);
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      addr_q       <= '0;
      word_tmr_q   <= '0;
      ack_tmr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      word_tmr_q   <= word_tmr_d;
      ack_tmr_q    <= ack_tmr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus_io.o_wr_en      = wr_en_q;
  assign bus_io.o_wr_addr    = wr_addr_q;
  assign bus_io.o_wr_data    = wr_data_q;
  assign bus_io.o_rd_en      = rd_en_q;
  assign bus_io.o_rd_addr    = rd_addr_q;
  assign bus_io.o_tx_valid   = tx_valid_q;
  assign bus_io.o_tx_data    = tx_data_q;
  assign bus_io.o_err        = err_q;
  assign bus_io.o_err_sticky = err_sticky_q;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Directed bench for spi_cmd_parser: table of single-word steps plus multi-cycle read,
// timeout and reset sequences.
module tb_spi_cmd_parser;

  logic user_clk = 1'b0;
  logic user_rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 user_clk = ~user_clk;

  spi_cmd_parser_if #(.WORD_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  spi_cmd_parser #(
    .WORD_WIDTH  (16),
    .ADDR_WIDTH  (8),
    .WORD_TIMEOUT(32'd4000),
    .ACK_TIMEOUT (32'd256)
  ) dut (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .bus_io    (bus)
  );

  typedef struct {
    logic        rst;
    logic [15:0] word;
    logic        ew;
    logic [7:0]  ewa;
    logic [15:0] ewd;
    logic        er;
    logic [7:0]  era;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    bus.i_rx_data = w;
    bus.i_rx_evt  = 1'b1;
    tick();
    bus.i_rx_evt  = 1'b0;
  endtask

  task automatic do_reset();
    user_rst_n = 1'b0;
    tick();
    tick();
    user_rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " wr_en"},    32'(bus.o_wr_en),      32'd0);
    chk({tag, " wr_addr"},  32'(bus.o_wr_addr),    32'd0);
    chk({tag, " wr_data"},  32'(bus.o_wr_data),    32'd0);
    chk({tag, " rd_en"},    32'(bus.o_rd_en),      32'd0);
    chk({tag, " rd_addr"},  32'(bus.o_rd_addr),    32'd0);
    chk({tag, " tx_valid"}, 32'(bus.o_tx_valid),   32'd0);
    chk({tag, " tx_data"},  32'(bus.o_tx_data),    32'd0);
    chk({tag, " err"},      32'(bus.o_err),        32'd0);
    chk({tag, " sticky"},   32'(bus.o_err_sticky), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;

    //          rst   word      ew    ewa    ewd       er    era
    vecs[0] = '{1'b1, 16'h0012, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 16'hBEEF, 1'b1, 8'h12, 16'hBEEF, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 16'h00FE, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 16'h1111, 1'b1, 8'hFE, 16'h1111, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 16'h2222, 1'b1, 8'hFF, 16'h2222, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 16'h3333, 1'b1, 8'h00, 16'h3333, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 16'h7F80, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 16'h5A5A, 1'b1, 8'h80, 16'h5A5A, 1'b0, 8'h00};
    vecs[8] = '{1'b1, 16'h8034, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h34};
    vecs[9] = '{1'b0, 16'hFFFF, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00};

    bus.i_rx_evt  = 1'b0;
    bus.i_rx_data = '0;
    bus.i_rd_ack  = 1'b0;
    bus.i_rd_data = '0;
    bus.i_err_clr = 1'b0;
    do_reset();
    chk_all_zero("reset");

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst) do_reset();
      send(vecs[i].word);
      chk($sformatf("v%0d wr_en", i), 32'(bus.o_wr_en), 32'(vecs[i].ew));
      if (vecs[i].ew) begin
        chk($sformatf("v%0d wr_addr", i), 32'(bus.o_wr_addr), 32'(vecs[i].ewa));
        chk($sformatf("v%0d wr_data", i), 32'(bus.o_wr_data), 32'(vecs[i].ewd));
      end
      chk($sformatf("v%0d rd_en", i), 32'(bus.o_rd_en), 32'(vecs[i].er));
      if (vecs[i].er) chk($sformatf("v%0d rd_addr", i), 32'(bus.o_rd_addr), 32'(vecs[i].era));
    end

    // Burst read with ack three cycles after the request.
    do_reset();
    send(16'h8034);
    chk("rd req en", 32'(bus.o_rd_en), 32'd1);
    chk("rd req addr", 32'(bus.o_rd_addr), 32'h34);
    tick();
    chk("rd_en one cycle", 32'(bus.o_rd_en), 32'd0);
    tick();
    bus.i_rd_ack  = 1'b1;
    bus.i_rd_data = 16'h1234;
    tick();
    bus.i_rd_ack  = 1'b0;
    chk("rd tx_valid", 32'(bus.o_tx_valid), 32'd1);
    chk("rd tx_data", 32'(bus.o_tx_data), 32'h1234);
    bus.i_rd_ack  = 1'b1;
    bus.i_rd_data = 16'hDEAD;
    tick();
    bus.i_rd_ack  = 1'b0;
    chk("stray ack valid", 32'(bus.o_tx_valid), 32'd0);
    chk("stray ack data", 32'(bus.o_tx_data), 32'h1234);
    send(16'hAAAA);
    chk("dummy rd_en", 32'(bus.o_rd_en), 32'd1);
    chk("dummy rd_addr", 32'(bus.o_rd_addr), 32'h35);
    chk("dummy wr_en", 32'(bus.o_wr_en), 32'd0);

    // Ack timeout after a successful first read so tx_data must drop to zero.
    do_reset();
    send(16'h8010);
    tick();
    bus.i_rd_ack  = 1'b1;
    bus.i_rd_data = 16'h5555;
    tick();
    bus.i_rd_ack  = 1'b0;
    chk("to first data", 32'(bus.o_tx_data), 32'h5555);
    send(16'h0000);
    chk("to req addr", 32'(bus.o_rd_addr), 32'h11);
    n    = 0;
    seen = 1'b0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      tick();
      if (bus.o_err) begin
        seen = 1'b1;
        n    = k;
      end
    end
    chk("ack timeout latency", 32'(n), 32'd257);
    chk("to tx_valid", 32'(bus.o_tx_valid), 32'd1);
    chk("to tx_data", 32'(bus.o_tx_data), 32'h0);
    chk("to sticky", 32'(bus.o_err_sticky), 32'd1);
    tick();
    chk("err one cycle", 32'(bus.o_err), 32'd0);
    chk("sticky holds", 32'(bus.o_err_sticky), 32'd1);
    bus.i_err_clr = 1'b1;
    tick();
    bus.i_err_clr = 1'b0;
    chk("sticky cleared", 32'(bus.o_err_sticky), 32'd0);
    send(16'h0000);
    chk("post-to rd_addr", 32'(bus.o_rd_addr), 32'h12);

    // Word arriving in the expiry cycle is kept; a full silence ends the frame.
    do_reset();
    send(16'h0005);
    repeat (3999) tick();
    send(16'h9999);
    chk("edge wr_en", 32'(bus.o_wr_en), 32'd1);
    chk("edge wr_addr", 32'(bus.o_wr_addr), 32'h05);
    chk("edge wr_data", 32'(bus.o_wr_data), 32'h9999);
    repeat (4000) tick();
    send(16'h0007);
    chk("frame end no write", 32'(bus.o_wr_en), 32'd0);
    send(16'h4242);
    chk("new frame wr_en", 32'(bus.o_wr_en), 32'd1);
    chk("new frame wr_addr", 32'(bus.o_wr_addr), 32'h07);
    chk("new frame wr_data", 32'(bus.o_wr_data), 32'h4242);

    // Reset while waiting for an ack; the late ack must be ignored.
    send(16'h0000);
    do_reset();
    send(16'h8020);
    tick();
    tick();
    user_rst_n = 1'b0;
    tick();
    user_rst_n = 1'b1;
    bus.i_rd_ack  = 1'b1;
    bus.i_rd_data = 16'hBEEF;
    tick();
    bus.i_rd_ack  = 1'b0;
    chk_all_zero("mid-read reset");
    send(16'h0003);
    chk("after reset hdr", 32'(bus.o_wr_en), 32'd0);
    send(16'h4444);
    chk("after reset wr_en", 32'(bus.o_wr_en), 32'd1);
    chk("after reset wr_addr", 32'(bus.o_wr_addr), 32'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
